rgb_digit_sched: RTL and testbench
==================================

RGB_DIGIT_SCHED -- requirements
Module: rgb_digit_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port val_r / val_g / val_b, input, 8 bits each: channel values to display.
REQ-004 SHALL have port val_load, input, 1 bit: load strobe, accepted only while val_ready=1.
REQ-005 SHALL have port val_ready, output, 1 bit: high when in IDLE.
REQ-006 SHALL have port line_req, input, 1 bit: level request for one glyph row fetch; held high until line_done.
REQ-007 SHALL have port row_idx, input, 4 bits: glyph row 0..15, sampled when line_req is accepted.
REQ-008 SHALL have port rom_en, output, 1 bit: read enable for the shared glyph ROM.
REQ-009 SHALL have port rom_addr, output, 8 bits: {digit[3:0], row[3:0]}.
REQ-010 SHALL have port rom_data, input, 16 bits: glyph row, valid one cycle after rom_en.
REQ-011 SHALL have port char_rows, output, 144 bits: 9 glyph rows, slot k at [16k+15:16k], order R_h,R_d,R_u,G_h,G_d,G_u,B_h,B_d,B_u.
REQ-012 SHALL have port line_done, output, 1 bit: single-cycle pulse when char_rows is updated.

Function
REQ-013 SHALL implement FSM states IDLE, CONV, FETCH, DONE.
REQ-014 SHALL, in IDLE with line_req=1, go to FETCH (line_req wins over simultaneous val_load; val_load then ignored).
REQ-015 SHALL, in IDLE with val_load=1 and line_req=0, latch val_r/g/b and go to CONV.
REQ-016 SHALL convert all three channels to BCD in parallel by shift-add-3, exactly 8 cycles in CONV, then commit digits atomically and return to IDLE.
REQ-017 SHALL hold previously committed digits until commit; digits before first load are 0.
REQ-018 SHALL, with acceptance at cycle T, drive rom_en=1 and rom_addr={digit_k,row_idx} in cycle T+1+k, k=0..8.
REQ-019 SHALL capture rom_data for slot k in a shadow buffer at cycle T+2+k.
REQ-020 SHALL copy the shadow buffer to char_rows and pulse line_done at cycle T+11 (DONE), then return to IDLE.
REQ-021 SHALL keep rom_en=0 and rom_addr=0 outside FETCH issue cycles.
REQ-022 SHALL leave char_rows unchanged except at the DONE cycle; no partial update is ever visible.
REQ-023 SHALL ignore line_req still high in the cycle after DONE (one fetch per rising request; re-arm requires line_req=0 for at least one cycle).

Reset
REQ-024 SHALL, on rst_n=0 at any time (including mid-CONV or mid-FETCH), go to IDLE, abandon the operation, and clear digits, shadow buffer, char_rows, line_done, rom_en, rom_addr to 0; val_ready=1 after reset.

Configuration
REQ-025 SHALL, with macro RGB_DIGIT_LEAD_BLANK_EN defined, blank a hundreds digit of 0 and a tens digit of 0 when its hundreds is also 0: slot loaded with 16'h0000, rom_en=0 in that slot's issue cycle, timing unchanged.
REQ-026 SHALL, without RGB_DIGIT_LEAD_BLANK_EN, fetch all 9 digits from ROM; units digit is never blanked in either build.

Structure
REQ-027 SHALL place NUM_CH=3, DIG_PER_CH=3, NUM_SLOT=9, GLYPH_W=16, GLYPH_H=16, the FSM state typedef and fetch latency constant 11 in package rgb_digit_pkg.
REQ-028 SHALL instantiate one sub-module bin2bcd8 (8-bit sequential shift-add-3 converter) per channel.

Verification
REQ-029 SHALL cover: reset, load R=255,G=128,B=7 -> val_ready low 8 cycles, digits 2,5,5,1,2,8,0,0,7.
REQ-030 SHALL cover: line_req row_idx=3 -> rom_addr 0x23,0x53,0x53,0x13,0x23,0x83,0x03,0x03,0x73 on T+1..T+9, line_done at T+11.
REQ-031 SHALL cover: val_load and line_req same IDLE cycle -> FETCH taken with old digits, load dropped.
REQ-032 SHALL cover: rst_n low at T+5 of fetch -> char_rows=0, no line_done, IDLE next cycle.
REQ-033 SHALL cover (LEAD_BLANK_EN): B=7 -> slots 6,7 =16'h0000 with rom_en low; G=0 -> slot 5 fetched (digit 0).
REQ-034 SHALL cover: line_req held high across 3 fetch periods -> exactly one line_done until line_req drops.

Source files
------------

// File: rtl/rgb_digit_pkg.sv
// Shared constants and types for the RGB digit scheduler.
// Contents: slot/glyph geometry, FSM state type, digit storage type and the
// leading-zero blanking helper used when RGB_DIGIT_LEAD_BLANK_EN is defined.
package rgb_digit_pkg;

  localparam int NUM_CH     = 3;
  localparam int DIG_PER_CH = 3;
  localparam int NUM_SLOT   = NUM_CH * DIG_PER_CH;
  localparam int GLYPH_W    = 16;
  localparam int GLYPH_H    = 16;
  // Accept cycle to line_done cycle distance.
  localparam int FETCH_LAT  = 11;
  localparam int CONV_CYC   = 8;

  typedef enum logic [1:0] {IDLE, CONV, FETCH, DONE} state_e;

  // Slot order per channel: hundreds, tens, units (slot 0 = R hundreds).
  typedef logic [NUM_SLOT-1:0][3:0] digits_t;

  // A hundreds digit of 0 is blank; a tens digit of 0 is blank only when
  // its hundreds digit is also 0. Units digits are never blank.
  function automatic logic lead_blank(input digits_t d, input logic [3:0] k);
    logic b;
    b = 1'b0;
    case (k)
      4'd0, 4'd3, 4'd6: b = (d[k] == 4'd0);
      4'd1, 4'd4, 4'd7: b = (d[k] == 4'd0) && (d[k-4'd1] == 4'd0);
      default:          b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rgb_digit_sched_if.sv
// Bus bundle for rgb_digit_sched.
//   val_r/g/b, val_load, val_ready : value load handshake
//   line_req, row_idx, line_done   : glyph row fetch handshake
//   rom_en, rom_addr, rom_data     : shared glyph ROM port (1-cycle latency)
//   char_rows                      : 9 committed glyph rows, slot k at [16k+15:16k]
// slave = the scheduler, master = its environment.
interface rgb_digit_sched_if;
  import rgb_digit_pkg::*;

  logic [7:0]                  val_r, val_g, val_b;
  logic                        val_load;
  logic                        val_ready;
  logic                        line_req;
  logic [3:0]                  row_idx;
  logic                        rom_en;
  logic [7:0]                  rom_addr;
  logic [GLYPH_W-1:0]          rom_data;
  logic [NUM_SLOT*GLYPH_W-1:0] char_rows;
  logic                        line_done;

  modport slave (
    input  val_r, val_g, val_b, val_load, line_req, row_idx, rom_data,
    output val_ready, rom_en, rom_addr, char_rows, line_done
  );

  modport master (
    output val_r, val_g, val_b, val_load, line_req, row_idx, rom_data,
    input  val_ready, rom_en, rom_addr, char_rows, line_done
  );

endinterface

// File: rtl/rgb_digit_sched_bin2bcd8.sv
// bin2bcd8: 8-bit binary to 3-digit BCD, sequential shift-add-3.
// Ports: clk, rst_n (async low), start_i loads bin_i, step_i runs one
// iteration; bcd_next_o is the BCD field as it will be after the current
// step, so the owner can commit on the 8th step cycle without an extra cycle.
module bin2bcd8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_next_o
);

  // [19:8] BCD field, [7:0] binary still to be shifted in
  logic [19:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    for (int n = 0; n < 3; n++) begin
      if (sr_d[8+4*n +: 4] >= 4'd5) sr_d[8+4*n +: 4] = sr_d[8+4*n +: 4] + 4'd3;
    end
    sr_d = {sr_d[18:0], 1'b0};
  end

  assign bcd_next_o = sr_d[19:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr_q <= '0;
    else if (start_i) sr_q <= {12'd0, bin_i};
    else if (step_i)  sr_q <= sr_d;
  end

endmodule

// File: rtl/rgb_digit_sched.sv
// rgb_digit_sched: converts three 8-bit channel values to decimal digits and
// fetches the glyph row of each of the 9 digits from a shared ROM, publishing
// all 9 rows atomically with a line_done pulse.
// Ports: clk, rst_n (async low), bus (rgb_digit_sched_if.slave).
// Option: RGB_DIGIT_LEAD_BLANK_EN blanks leading zero hundreds/tens digits
// (slot loaded with 0, no ROM read, timing unchanged).
module rgb_digit_sched
  import rgb_digit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rgb_digit_sched_if.slave   bus
);

  state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] row_q;
  logic       arm_q;
  digits_t    digits_q, commit_dig;
  logic [NUM_SLOT-1:0][GLYPH_W-1:0] shadow_q, shadow_d, rows_q;

  logic conv_start, conv_step, commit, fetch_go, publish;
  logic blank_issue, blank_cap;
  logic [NUM_CH-1:0][7:0]  val;
  logic [NUM_CH-1:0][11:0] bcd_next;

  assign val = {bus.val_b, bus.val_g, bus.val_r};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_conv
    bin2bcd8 u_conv (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (conv_start),
      .step_i     (conv_step),
      .bin_i      (val[c]),
      .bcd_next_o (bcd_next[c])
    );
    assign commit_dig[c*DIG_PER_CH+0] = bcd_next[c][11:8];
    assign commit_dig[c*DIG_PER_CH+1] = bcd_next[c][7:4];
    assign commit_dig[c*DIG_PER_CH+2] = bcd_next[c][3:0];
  end

  // Issue slot is cnt_q; the slot whose data is on rom_data is cnt_q-1.
`ifdef RGB_DIGIT_LEAD_BLANK_EN
  assign blank_issue = lead_blank(digits_q, cnt_q);
  assign blank_cap   = lead_blank(digits_q, cnt_q - 4'd1);
`else
  assign blank_issue = 1'b0;
  assign blank_cap   = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    conv_start    = 1'b0;
    conv_step     = 1'b0;
    commit        = 1'b0;
    fetch_go      = 1'b0;
    publish       = 1'b0;
    bus.val_ready = 1'b0;
    bus.rom_en    = 1'b0;
    bus.rom_addr  = 8'd0;
    bus.line_done = 1'b0;
    case (state_q)
      IDLE: begin
        bus.val_ready = 1'b1;
        // A fetch request beats a simultaneous load; the load is dropped.
        if (bus.line_req && arm_q) begin
          state_d  = FETCH;
          cnt_d    = 4'd0;
          fetch_go = 1'b1;
        end else if (bus.val_load) begin
          state_d    = CONV;
          cnt_d      = 4'd0;
          conv_start = 1'b1;
        end
      end
      CONV: begin
        conv_step = 1'b1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'(CONV_CYC-1)) begin
          commit  = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      FETCH: begin
        if (cnt_q < 4'(NUM_SLOT) && !blank_issue) begin
          bus.rom_en   = 1'b1;
          bus.rom_addr = {digits_q[cnt_q], row_q};
        end
        cnt_d = cnt_q + 4'd1;
        // Last cycle captures slot 8 and publishes in the same edge.
        if (cnt_q == 4'(FETCH_LAT-2)) begin
          publish = 1'b1;
          state_d = DONE;
          cnt_d   = 4'd0;
        end
      end
      DONE: begin
        bus.line_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (state_q == FETCH && cnt_q != 4'd0)
      shadow_d[cnt_q-4'd1] = blank_cap ? '0 : bus.rom_data;
  end

  assign bus.char_rows = rows_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      arm_q    <= 1'b1;
      digits_q <= '0;
      shadow_q <= '0;
      rows_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      if (fetch_go) row_q    <= bus.row_idx;
      if (commit)   digits_q <= commit_dig;
      if (publish)  rows_q   <= shadow_d;
      // One fetch per rising request: re-arm only after line_req drops.
      if (!bus.line_req) arm_q <= 1'b1;
      else if (fetch_go) arm_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgb_digit_sched.sv
module tb_rgb_digit_sched;
  import rgb_digit_pkg::*;

`ifdef RGB_DIGIT_LEAD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [143:0] exp_prev;

  rgb_digit_sched_if bus();

  rgb_digit_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  // ROM model: 1-cycle latency, contents {addr, ~addr}; junk when not read.
  always @(posedge clk) bus.rom_data <= bus.rom_en ? {bus.rom_addr, ~bus.rom_addr} : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.val_r = 0; bus.val_g = 0; bus.val_b = 0; bus.val_load = 0;
    bus.line_req = 0; bus.row_idx = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.val_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h exp 1", bus.val_ready); end
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL rst_rom_en got %0h exp 0", bus.rom_en); end
    checks++; if (bus.rom_addr !== 8'h00) begin errors++; $display("FAIL rst_rom_addr got %0h exp 0", bus.rom_addr); end
    checks++; if (bus.line_done !== 1'b0) begin errors++; $display("FAIL rst_line_done got %0h exp 0", bus.line_done); end
    checks++; if (bus.char_rows !== 144'd0) begin errors++; $display("FAIL rst_char_rows got %0h exp 0", bus.char_rows); end
    rst_n = 1;
    tick();
  endtask

  // Load and fetch in the same IDLE cycle: fetch wins with the reset digits.
  task automatic test_collide();
    bus.val_r = 8'd255; bus.val_g = 8'd128; bus.val_b = 8'd7;
    bus.val_load = 1; bus.line_req = 1; bus.row_idx = 4'd1;
    tick();                                   // T+1
    bus.val_load = 0;
    checks++; if (bus.rom_en !== (BLANK ? 1'b0 : 1'b1)) begin errors++; $display("FAIL collide_en0 got %0h exp %0h", bus.rom_en, !BLANK); end
    tick(); tick();                           // T+3, slot 2 (R units)
    checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 8'h01) begin errors++; $display("FAIL collide_slot2 got en %0h addr %0h exp en 1 addr 01", bus.rom_en, bus.rom_addr); end
    repeat (8) tick();                        // T+11
    for (int k = 0; k < 9; k++) exp_prev[k*16 +: 16] = (BLANK && (k % 3) != 2) ? 16'h0000 : 16'h01FE;
    checks++; if (bus.line_done !== 1'b1) begin errors++; $display("FAIL collide_done got %0h exp 1", bus.line_done); end
    checks++; if (bus.char_rows !== exp_prev) begin errors++; $display("FAIL collide_rows got %0h exp %0h", bus.char_rows, exp_prev); end
    bus.line_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.val_ready !== 1'b1) begin errors++; $display("FAIL collide_no_conv cyc %0d got %0h exp 1", i, bus.val_ready); end
    end
  endtask

  task automatic test_load();
    bus.val_r = 8'd255; bus.val_g = 8'd128; bus.val_b = 8'd7; bus.val_load = 1;
    tick();
    bus.val_load = 0;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (bus.val_ready !== 1'b0) begin errors++; $display("FAIL load_busy L+%0d got %0h exp 0", i, bus.val_ready); end
      tick();
    end
    checks++; if (bus.val_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back got %0h exp 1", bus.val_ready); end
  endtask

  // Digits 2,5,5,1,2,8,0,0,7 fetched for row 3.
  task automatic test_fetch();
    logic [7:0]   ea [9];
    logic [8:0]   een;
    logic [143:0] er;
    ea  = '{8'h23, 8'h53, 8'h53, 8'h13, 8'h23, 8'h83, 8'h03, 8'h03, 8'h73};
    een = 9'h1FF;
    if (BLANK) begin ea[6] = 8'h00; ea[7] = 8'h00; een = 9'h13F; end
    for (int k = 0; k < 9; k++) er[k*16 +: 16] = een[k] ? {ea[k], ~ea[k]} : 16'h0000;
    bus.row_idx = 4'd3; bus.line_req = 1;
    tick();
    for (int k = 0; k < 9; k++) begin
      checks++; if (bus.rom_en !== een[k] || bus.rom_addr !== ea[k]) begin errors++; $display("FAIL fetch_slot%0d got en %0h addr %0h exp en %0h addr %0h", k, bus.rom_en, bus.rom_addr, een[k], ea[k]); end
      checks++; if (bus.char_rows !== exp_prev || bus.line_done !== 1'b0) begin errors++; $display("FAIL fetch_hold%0d got rows %0h done %0h exp rows %0h done 0", k, bus.char_rows, bus.line_done, exp_prev); end
      tick();
    end
    checks++; if (bus.rom_en !== 1'b0 || bus.rom_addr !== 8'h00) begin errors++; $display("FAIL fetch_idle_bus got en %0h addr %0h exp 0 0", bus.rom_en, bus.rom_addr); end
    checks++; if (bus.char_rows !== exp_prev || bus.line_done !== 1'b0) begin errors++; $display("FAIL fetch_t10 got rows %0h done %0h exp rows %0h done 0", bus.char_rows, bus.line_done, exp_prev); end
    tick();                                   // T+11
    checks++; if (bus.line_done !== 1'b1) begin errors++; $display("FAIL fetch_done got %0h exp 1", bus.line_done); end
    checks++; if (bus.char_rows !== er) begin errors++; $display("FAIL fetch_rows got %0h exp %0h", bus.char_rows, er); end
    exp_prev = er;
    bus.line_req = 0;
    tick();
    checks++; if (bus.line_done !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse got %0h exp 0", bus.line_done); end
  endtask

  // R=100,G=0,B=7 -> digits 1,0,0,0,0,0,0,0,7, row 0xA.
  task automatic test_blank();
    logic [7:0]   ea [9];
    logic [8:0]   een;
    logic [143:0] er;
    bus.val_r = 8'd100; bus.val_g = 8'd0; bus.val_b = 8'd7; bus.val_load = 1;
    tick();
    bus.val_load = 0;
    repeat (8) tick();
    ea  = '{8'h1A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h7A};
    een = 9'h1FF;
    if (BLANK) begin ea[3] = 0; ea[4] = 0; ea[6] = 0; ea[7] = 0; een = 9'h127; end
    for (int k = 0; k < 9; k++) er[k*16 +: 16] = een[k] ? {ea[k], ~ea[k]} : 16'h0000;
    bus.row_idx = 4'hA; bus.line_req = 1;
    tick();
    for (int k = 0; k < 9; k++) begin
      checks++; if (bus.rom_en !== een[k] || bus.rom_addr !== ea[k]) begin errors++; $display("FAIL blank_slot%0d got en %0h addr %0h exp en %0h addr %0h", k, bus.rom_en, bus.rom_addr, een[k], ea[k]); end
      tick();
    end
    tick();                                   // T+11
    checks++; if (bus.line_done !== 1'b1) begin errors++; $display("FAIL blank_done got %0h exp 1", bus.line_done); end
    checks++; if (bus.char_rows !== er) begin errors++; $display("FAIL blank_rows got %0h exp %0h", bus.char_rows, er); end
    exp_prev = er;
    bus.line_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bus.row_idx = 4'd3; bus.line_req = 1;
    repeat (5) tick();                        // T+5
    rst_n = 0;
    #1;
    checks++; if (bus.char_rows !== 144'd0) begin errors++; $display("FAIL rmid_rows got %0h exp 0", bus.char_rows); end
    checks++; if (bus.line_done !== 1'b0 || bus.rom_en !== 1'b0 || bus.rom_addr !== 8'h00) begin errors++; $display("FAIL rmid_outs got done %0h en %0h addr %0h exp 0 0 0", bus.line_done, bus.rom_en, bus.rom_addr); end
    checks++; if (bus.val_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0h exp 1", bus.val_ready); end
    bus.line_req = 0;
    rst_n = 1;
    tick();
    checks++; if (bus.val_ready !== 1'b1 || bus.rom_en !== 1'b0) begin errors++; $display("FAIL rmid_idle got ready %0h en %0h exp 1 0", bus.val_ready, bus.rom_en); end
    n = 0;
    repeat (10) begin if (bus.line_done === 1'b1) n++; tick(); end
    checks++; if (n != 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", n); end
    exp_prev = '0;
  endtask

  task automatic test_held();
    int n, lat;
    bus.row_idx = 4'd0; bus.line_req = 1;
    n = 0;
    repeat (36) begin if (bus.line_done === 1'b1) n++; tick(); end
    checks++; if (n != 1) begin errors++; $display("FAIL held_one_done got %0d exp 1", n); end
    bus.line_req = 0;
    tick();
    bus.line_req = 1;
    lat = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.line_done === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != FETCH_LAT) begin errors++; $display("FAIL held_rearm_lat got %0d exp %0d", lat, FETCH_LAT); end
    bus.line_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_collide();
    test_load();
    test_fetch();
    test_blank();
    test_reset_mid();
    test_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
